// File: rtl/data_mem_arbiter.sv
// Core/debug arbiter for the shared single-ported data memory. The core has fixed
// priority; a saturating starvation counter forces debug through under continuous core traffic.
module data_mem_arbiter #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  core_op,
  input  logic [15:0] core_addr,
  input  logic [15:0] core_wdata,
  output logic        core_stall,
  output logic [15:0] core_rdata,
  output logic        core_rvalid,
  output logic        core_err,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic [15:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic        dbg_err,
  output logic [1:0]  mem_op,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam logic [1:0]  MEM_IDLE  = 2'b00;
  localparam logic [1:0]  MEM_READ  = 2'b01;
  localparam logic [1:0]  MEM_WRITE = 2'b10;
  localparam int unsigned AW        = 16;
  localparam int unsigned AXW       = AW + 1;
  localparam int unsigned CNT_W     = 4;

  localparam logic [AXW-1:0]   DEPTH_EXT = AXW'(DEPTH);
  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [CNT_W-1:0] starve_cnt;
  logic             core_act;
  logic             dbg_force;
  logic             core_win;
  logic             dbg_win;
  logic             core_oor;
  logic             dbg_oor;
  logic             core_rd;
  logic             dbg_rd;

  // Arbitration and memory-port mux; all grants are suppressed while reset is low.
  always_comb begin
    core_act   = (core_op == MEM_READ) || (core_op == MEM_WRITE);
    dbg_force  = dbg_req && (starve_cnt == LIMIT);
    core_win   = reset && core_act && !dbg_force;
    dbg_win    = reset && dbg_req && !core_win;
    core_oor   = {1'b0, core_addr} >= DEPTH_EXT;
    dbg_oor    = {1'b0, dbg_addr} >= DEPTH_EXT;
    core_rd    = core_win && (core_op == MEM_READ);
    dbg_rd     = dbg_win && !dbg_we;
    mem_op     = MEM_IDLE;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (core_win) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      if (!core_oor) mem_op = core_op;
    end else if (dbg_win) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      if (!dbg_oor) mem_op = dbg_we ? MEM_WRITE : MEM_READ;
    end
    core_stall = core_act && !core_win;
    dbg_gnt    = dbg_win;
  end

  // Read return, error strobes and starvation tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_rdata  <= '0;
      core_rvalid <= 1'b0;
      core_err    <= 1'b0;
      dbg_rdata   <= '0;
      dbg_rvalid  <= 1'b0;
      dbg_err     <= 1'b0;
      starve_cnt  <= '0;
    end else begin
      core_rvalid <= core_rd;
      core_err    <= core_win && core_oor;
      dbg_rvalid  <= dbg_rd;
      dbg_err     <= dbg_win && dbg_oor;
      if (core_rd) core_rdata <= core_oor ? '0 : mem_rdata;
      if (dbg_rd)  dbg_rdata  <= dbg_oor ? '0 : mem_rdata;
      if (!dbg_req || dbg_win) begin
        starve_cnt <= '0;
      end else if (core_win && (starve_cnt != CNT_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level reference model of the arbiter and memory.
module tb_data_mem_arbiter;

  localparam logic [1:0]  IDLE  = 2'b00;
  localparam logic [1:0]  RD    = 2'b01;
  localparam logic [1:0]  WR    = 2'b10;
  localparam int unsigned LIMIT = 4;
  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  core_op = IDLE;
  logic [15:0] core_addr = '0;
  logic [15:0] core_wdata = '0;
  logic        core_stall;
  logic [15:0] core_rdata;
  logic        core_rvalid;
  logic        core_err;
  logic        dbg_req = 1'b0;
  logic        dbg_we = 1'b0;
  logic [15:0] dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic        dbg_gnt;
  logic [15:0] dbg_rdata;
  logic        dbg_rvalid;
  logic        dbg_err;
  logic [1:0]  mem_op;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .core_op(core_op), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .core_err(core_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid), .dbg_err(dbg_err),
    .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory-manager fixture: 256 words, write captured at the edge and committed before the next read.
  logic [15:0] mem [0:255];
  logic        pend_we;
  logic [7:0]  pend_a;
  logic [15:0] pend_d;
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    pend_we <= (mem_op == WR);
    pend_a  <= mem_addr[7:0];
    pend_d  <= mem_wdata;
  end

  // Reference model state.
  logic [15:0] ref_mem [0:255];
  int unsigned waited = 0;
  logic [15:0] m_crd = '0, m_drd = '0;
  logic        m_crv = 1'b0, m_cerr = 1'b0, m_drv = 1'b0, m_derr = 1'b0;
  logic        last_core_stall = 1'b0, last_dbg_gnt = 1'b0;
  logic [15:0] init0;

  int checks = 0;
  int errors = 0;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_crd = '0; m_drd = '0; m_crv = 1'b0; m_cerr = 1'b0; m_drv = 1'b0; m_derr = 1'b0;
    waited = 0;
  endtask

  // One clock cycle: check last edge's registered results, drive, check the grant, advance the model.
  task automatic cycle(input logic rst, input logic [1:0] cop, input logic [15:0] ca,
                       input logic [15:0] cw, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [15:0] dd);
    logic c_act, g_c, g_d, c_oor, d_oor;
    logic [1:0]  e_op;
    logic [15:0] e_addr, e_wd;
    @(negedge clk);
    if (pend_we === 1'b1) mem[pend_a] = pend_d;
    chk1("core_rvalid", core_rvalid, m_crv);
    chk16("core_rdata", core_rdata, m_crd);
    chk1("core_err", core_err, m_cerr);
    chk1("dbg_rvalid", dbg_rvalid, m_drv);
    chk16("dbg_rdata", dbg_rdata, m_drd);
    chk1("dbg_err", dbg_err, m_derr);
    reset = rst; core_op = cop; core_addr = ca; core_wdata = cw;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    #1;
    c_act = (cop == RD) || (cop == WR);
    g_c   = rst && c_act && !(dr && (waited >= LIMIT));
    g_d   = rst && dr && !g_c;
    c_oor = {16'b0, ca} >= DEPTH;
    d_oor = {16'b0, da} >= DEPTH;
    e_op = IDLE; e_addr = '0; e_wd = '0;
    if (g_c) begin
      e_addr = ca; e_wd = cw; e_op = c_oor ? IDLE : cop;
    end else if (g_d) begin
      e_addr = da; e_wd = dd; e_op = d_oor ? IDLE : (dw ? WR : RD);
    end
    chk16("mem_op", {14'b0, mem_op}, {14'b0, e_op});
    chk16("mem_addr", mem_addr, e_addr);
    chk16("mem_wdata", mem_wdata, e_wd);
    chk1("core_stall", core_stall, c_act && !g_c);
    chk1("dbg_gnt", dbg_gnt, g_d);
    m_crv  = g_c && (cop == RD);
    m_cerr = g_c && c_oor;
    if (m_crv) m_crd = c_oor ? 16'h0 : ref_mem[ca[7:0]];
    if (g_c && (cop == WR) && !c_oor) ref_mem[ca[7:0]] = cw;
    m_drv  = g_d && !dw;
    m_derr = g_d && d_oor;
    if (m_drv) m_drd = d_oor ? 16'h0 : ref_mem[da[7:0]];
    if (g_d && dw && !d_oor) ref_mem[da[7:0]] = dd;
    if (!rst) model_reset();
    else if (!dr || g_d) waited = 0;
    else if (waited < 15) waited = waited + 1;
    last_core_stall = c_act && !g_c;
    last_dbg_gnt    = g_d;
  endtask

  logic [1:0]  rcop = IDLE;
  logic [15:0] rca = '0, rcw = '0, rda = '0, rdd = '0;
  logic        rdr = 1'b0, rdw = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    init0 = ref_mem[0];

    // Reset held with both requesters asking.
    cycle(0, RD, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0);
    cycle(0, RD, 16'h0010, 16'h0, 1, 0, 16'h0020, 16'h0);
    chk16("rst_mem_op", {14'b0, mem_op}, 16'h0);
    chk1("rst_core_stall", core_stall, 1'b1);
    chk1("rst_dbg_gnt", dbg_gnt, 1'b0);

    // Core-only write then read back.
    cycle(1, WR, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0);
    chk1("wr_stall", core_stall, 1'b0);
    chk16("wr_mem_op", {14'b0, mem_op}, {14'b0, WR});
    chk16("wr_mem_addr", mem_addr, 16'h0010);
    cycle(1, RD, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk1("rd_rvalid", core_rvalid, 1'b1);
    chk16("rd_beef", core_rdata, 16'hBEEF);

    // Contention: debug write forced through on the fifth cycle.
    for (int i = 0; i < 5; i++) begin
      cycle(1, RD, 16'(16'h0030 + i), 16'h0, 1, 1, 16'h0020, 16'h1234);
      chk1("contend_gnt", dbg_gnt, i == 4);
      chk1("contend_stall", core_stall, i == 4);
    end
    cycle(1, IDLE, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0);
    @(posedge clk); #1;
    chk1("dbg_rd_rvalid", dbg_rvalid, 1'b1);
    chk16("dbg_rd_1234", dbg_rdata, 16'h1234);

    // Out-of-range core write must not alias onto word 0.
    cycle(1, WR, 16'h0100, 16'hDEAD, 0, 0, 16'h0, 16'h0);
    chk16("oor_mem_op", {14'b0, mem_op}, 16'h0);
    @(posedge clk); #1;
    chk1("oor_core_err", core_err, 1'b1);
    cycle(1, RD, 16'h0000, 16'h0, 0, 0, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk16("oor_word0", core_rdata, init0);

    // Out-of-range debug read.
    cycle(1, IDLE, 16'h0, 16'h0, 1, 0, 16'hFFFF, 16'h0);
    chk1("dbg_oor_gnt", dbg_gnt, 1'b1);
    @(posedge clk); #1;
    chk1("dbg_oor_rvalid", dbg_rvalid, 1'b1);
    chk16("dbg_oor_rdata", dbg_rdata, 16'h0);
    chk1("dbg_oor_err", dbg_err, 1'b1);

    // Reset asserted inside a core read grant cycle, with debug partly starved.
    cycle(1, RD, 16'h0040, 16'h0, 1, 1, 16'h0050, 16'h5555);
    cycle(1, RD, 16'h0041, 16'h0, 1, 1, 16'h0050, 16'h5555);
    cycle(1, RD, 16'h0042, 16'h0, 1, 1, 16'h0050, 16'h5555);
    #2 reset = 1'b0;
    #1;
    chk16("midrst_mem_op", {14'b0, mem_op}, 16'h0);
    chk16("midrst_mem_addr", mem_addr, 16'h0);
    chk1("midrst_stall", core_stall, 1'b1);
    chk1("midrst_dbg_gnt", dbg_gnt, 1'b0);
    model_reset();
    last_core_stall = 1'b1;
    last_dbg_gnt = 1'b0;
    cycle(0, RD, 16'h0042, 16'h0, 1, 1, 16'h0050, 16'h5555);
    for (int i = 0; i < 5; i++) begin
      cycle(1, RD, 16'h0042, 16'h0, 1, 1, 16'h0050, 16'h5555);
      chk1("post_rst_gnt", dbg_gnt, i == 4);
    end
    cycle(1, RD, 16'h0042, 16'h0, 0, 0, 16'h0, 16'h0);
    @(posedge clk); #1;
    chk1("reissue_rvalid", core_rvalid, 1'b1);

    // Random traffic honouring the hold-until-granted protocol for both requesters.
    last_core_stall = 1'b0;
    last_dbg_gnt = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!last_core_stall) begin
        rcop = 2'($urandom_range(0, 3));
        rca  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
        rcw  = 16'($urandom);
      end
      if (!(rdr && !last_dbg_gnt)) begin
        rdr = ($urandom_range(0, 2) != 0);
        rdw = 1'($urandom_range(0, 1));
        rda = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
        rdd = 16'($urandom);
      end
      cycle(1, rcop, rca, rcw, rdr, rdw, rda, rdd);
    end
    cycle(1, IDLE, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
